// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and fetch FSM state type
package mips_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register (instr, pc, pc+4, valid) with load/hold/flush
import mips_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // Flush beats load; neither asserted means hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= NOP_WORD;
            r_pc       <= 32'h0;
            r_pc_plus4 <= PC_INC;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, fetch FSM, one-entry hold buffer, IF/ID register
import mips_pkg::*;

module instruction_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction_memory,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_drain_addr;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_hold_pc;

    logic         w_ready;
    logic [31:0]  w_target;
    logic         w_load;
    logic         w_flush;
    logic [31:0]  w_d_instr;
    logic [31:0]  w_d_pc;
    logic [31:0]  w_d_pc4;

    assign imem_req  = (r_state == FETCH) || (r_state == DRAIN);
    assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;
    assign w_ready   = imem_ready & imem_req;
    assign w_target  = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= PC_RESET;
            r_drain_addr <= 32'h0;
            r_hold_instr <= NOP_WORD;
            r_hold_pc    <= 32'h0;
        end else if (redirect) begin
            r_pc <= w_target;
            // An outstanding request must complete before the new PC can be issued.
            if (r_state == FETCH && !w_ready) begin
                r_state      <= DRAIN;
                r_drain_addr <= r_pc;
            end else if (r_state == DRAIN && !w_ready) begin
                r_state <= DRAIN;
            end else begin
                r_state <= FETCH;
            end
        end else begin
            case (r_state)
                IDLE: r_state <= FETCH;
                FETCH: begin
                    if (w_ready) begin
                        r_pc <= r_pc + PC_INC;
                        if (stall) begin
                            r_hold_instr <= imem_rdata;
                            r_hold_pc    <= r_pc;
                            r_state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) r_state <= FETCH;
                end
                DRAIN: begin
                    if (w_ready) r_state <= FETCH;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_flush = redirect || (r_state == FETCH && !w_ready && !stall);
        w_load  = !redirect && !stall &&
                  ((r_state == FETCH && w_ready) || r_state == HOLD);
        if (r_state == HOLD) begin
            w_d_instr = r_hold_instr;
            w_d_pc    = r_hold_pc;
        end else begin
            w_d_instr = imem_rdata;
            w_d_pc    = r_pc;
        end
        w_d_pc4 = w_d_pc + PC_INC;
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_instr    (w_d_instr),
        .i_pc       (w_d_pc),
        .i_pc_plus4 (w_d_pc4),
        .o_instr    (instruction_memory),
        .o_pc       (pc_out),
        .o_pc_plus4 (pc_plus4),
        .o_valid    (instr_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
`timescale 1ns/1ps

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instruction_memory, pc_out, pc_plus4;
    logic        instr_valid;

    logic        imem_req2, imem_ready2;
    logic [31:0] imem_addr2, imem_rdata2;
    logic [31:0] instruction_memory2, pc_out2, pc_plus4_2;
    logic        instr_valid2;

    int lat;
    int wait_cnt;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h0422_4032;
        if (a == 32'h4) return 32'h0464_4820;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory with 'lat' wait cycles per request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (imem_req && !imem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign imem_ready  = imem_req && (wait_cnt >= lat);
    assign imem_rdata  = word_at(imem_addr);
    assign imem_ready2 = imem_req2;
    assign imem_rdata2 = word_at(imem_addr2);

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instruction_memory(instruction_memory), .pc_out(pc_out),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid)
    );

    instruction_fetch #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .instruction_memory(instruction_memory2), .pc_out(pc_out2),
        .pc_plus4(pc_plus4_2), .instr_valid(instr_valid2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        lat = 0;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick();
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_checks++; if (instruction_memory !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instruction_memory); end
        n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_out: got %h expected 00000000", pc_out); end
        n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h expected 00000004", pc_plus4); end
        rst_n = 1'b1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b expected 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid: got %b expected 0", instr_valid); end
    endtask

    task automatic test_zero_wait();
        tick();
        n_checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL zw_word0: got v=%b pc=%h pc4=%h expected v=1 pc=00000000 pc4=00000004", instr_valid, pc_out, pc_plus4); end
        n_checks++; if (instruction_memory !== 32'h0422_4032) begin n_fail++; $display("FAIL zw_instr0: got %h expected 04224032", instruction_memory); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL zw_addr1: got %h expected 00000004", imem_addr); end
        tick();
        n_checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h4 || pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL zw_word1: got v=%b pc=%h pc4=%h expected v=1 pc=00000004 pc4=00000008", instr_valid, pc_out, pc_plus4); end
        n_checks++; if (instruction_memory !== 32'h0464_4820) begin n_fail++; $display("FAIL zw_instr1: got %h expected 04644820", instruction_memory); end
    endtask

    task automatic test_two_cycle();
        lat = 1;
        apply_reset();
        tick();
        tick();
        n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL lat_addr_stable: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL lat_bubble0: got %b expected 0", instr_valid); end
        tick();
        n_checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instruction_memory !== 32'h0422_4032) begin n_fail++; $display("FAIL lat_word0: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=04224032", instr_valid, pc_out, instruction_memory); end
        tick();
        n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL lat_bubble1: got v=%b addr=%h expected v=0 addr=00000004", instr_valid, imem_addr); end
        tick();
        n_checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h4 || pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL lat_word1: got v=%b pc=%h pc4=%h expected v=1 pc=00000004 pc4=00000008", instr_valid, pc_out, pc_plus4); end
    endtask

    task automatic test_stall_hold();
        lat = 0;
        apply_reset();
        tick();
        tick();
        tick();
        n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL st_addr8: got %h expected 00000008", imem_addr); end
        stall = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_hold_req: got %b expected 0", imem_req); end
        n_checks++; if (pc_out !== 32'h4 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL st_ifid_kept: got pc=%h v=%b expected pc=00000004 v=1", pc_out, instr_valid); end
        tick();
        tick();
        n_checks++; if (imem_req !== 1'b0 || pc_out !== 32'h4) begin n_fail++; $display("FAIL st_hold3: got req=%b pc=%h expected req=0 pc=00000004", imem_req, pc_out); end
        stall = 1'b0;
        tick();
        n_checks++; if (pc_out !== 32'h8 || pc_plus4 !== 32'hC || instr_valid !== 1'b1 || instruction_memory !== word_at(32'h8)) begin n_fail++; $display("FAIL st_release: got pc=%h pc4=%h v=%b instr=%h expected pc=00000008 pc4=0000000c v=1 instr=%h", pc_out, pc_plus4, instr_valid, instruction_memory, word_at(32'h8)); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL st_next_req: got req=%b addr=%h expected req=1 addr=0000000c", imem_req, imem_addr); end
        tick();
        n_checks++; if (pc_out !== 32'hC || instr_valid !== 1'b1) begin n_fail++; $display("FAIL st_after: got pc=%h v=%b expected pc=0000000c v=1", pc_out, instr_valid); end
    endtask

    task automatic test_redirect_drain();
        lat = 1;
        apply_reset();
        tick();
        tick();
        tick();
        n_checks++; if (pc_out !== 32'h0 || instr_valid !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL rd_pre: got pc=%h v=%b addr=%h expected pc=00000000 v=1 addr=00000004", pc_out, instr_valid, imem_addr); end
        redirect = 1'b1; redirect_pc = 32'h0000_0043;
        tick();
        redirect = 1'b0; redirect_pc = 32'h0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL rd_drain_addr: got req=%b addr=%h expected req=1 addr=00000004", imem_req, imem_addr); end
        n_checks++; if (instruction_memory !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush: got instr=%h v=%b expected instr=00000000 v=0", instruction_memory, instr_valid); end
        tick();
        n_checks++; if (instr_valid !== 1'b0 || instruction_memory !== 32'h0) begin n_fail++; $display("FAIL rd_discard: got instr=%h v=%b expected instr=00000000 v=0", instruction_memory, instr_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL rd_new_addr: got req=%b addr=%h expected req=1 addr=00000040", imem_req, imem_addr); end
        tick();
        tick();
        n_checks++; if (pc_out !== 32'h40 || instr_valid !== 1'b1 || instruction_memory !== word_at(32'h40)) begin n_fail++; $display("FAIL rd_target: got pc=%h v=%b instr=%h expected pc=00000040 v=1 instr=%h", pc_out, instr_valid, instruction_memory, word_at(32'h40)); end
    endtask

    task automatic test_redirect_zero_wait();
        lat = 0;
        apply_reset();
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0202;
        tick();
        redirect = 1'b0; redirect_pc = 32'h0;
        n_checks++; if (imem_addr !== 32'h200 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rz_issue: got req=%b addr=%h v=%b expected req=1 addr=00000200 v=0", imem_req, imem_addr, instr_valid); end
        tick();
        n_checks++; if (pc_out !== 32'h200 || instr_valid !== 1'b1 || pc_plus4 !== 32'h204) begin n_fail++; $display("FAIL rz_target: got pc=%h pc4=%h v=%b expected pc=00000200 pc4=00000204 v=1", pc_out, pc_plus4, instr_valid); end
    endtask

    task automatic test_redirect_in_hold();
        lat = 0;
        apply_reset();
        tick();
        tick();
        stall = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rh_hold: got req=%b expected 0", imem_req); end
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || instruction_memory !== 32'h0) begin n_fail++; $display("FAIL rh_flush: got instr=%h v=%b expected instr=00000000 v=0", instruction_memory, instr_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rh_addr: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
        tick();
        n_checks++; if (pc_out !== 32'h100 || instr_valid !== 1'b1 || instruction_memory !== word_at(32'h100)) begin n_fail++; $display("FAIL rh_target: got pc=%h v=%b instr=%h expected pc=00000100 v=1 instr=%h", pc_out, instr_valid, instruction_memory, word_at(32'h100)); end
    endtask

    task automatic test_pc_wrap();
        lat = 0;
        apply_reset();
        tick();
        n_checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first_addr: got %h expected fffffffc", imem_addr2); end
        tick();
        n_checks++; if (imem_addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_second_addr: got %h expected 00000000", imem_addr2); end
        n_checks++; if (pc_out2 !== 32'hFFFF_FFFC || pc_plus4_2 !== 32'h0 || instr_valid2 !== 1'b1) begin n_fail++; $display("FAIL wrap_ifid: got pc=%h pc4=%h v=%b expected pc=fffffffc pc4=00000000 v=1", pc_out2, pc_plus4_2, instr_valid2); end
        tick();
        n_checks++; if (pc_out2 !== 32'h0 || instruction_memory2 !== 32'h0422_4032) begin n_fail++; $display("FAIL wrap_next: got pc=%h instr=%h expected pc=00000000 instr=04224032", pc_out2, instruction_memory2); end
    endtask

    initial begin
        lat = 0;
        test_reset();
        test_zero_wait();
        test_two_cycle();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_zero_wait();
        test_redirect_in_hold();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the MIPS pipeline. It owns the program counter, requests 32-bit words from instruction memory over a req/ready handshake, and registers each fetched word with its PC into the IF/ID pipeline register. The control unit and the decode stage consume that register. The stage supports hazard stalls from downstream and PC redirects from branch/jump resolution.

## Interface
- `PC_RESET`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request; address valid while high.
- `imem_addr` out 32: word-aligned fetch address; bits [1:0] are always 0.
- `imem_ready` in 1: memory returns `imem_rdata` this cycle; ignored unless `imem_req`.
- `imem_rdata` in 32: fetched instruction word.
- `stall` in 1: downstream cannot accept; IF/ID holds its contents.
- `redirect` in 1: branch/jump taken; flush and refetch.
- `redirect_pc` in 32: target PC; bits [1:0] are ignored and forced to 0.
- `instruction_memory` out 32: IF/ID instruction word, fed to control and decode.
- `pc_out` out 32: PC of `instruction_memory`.
- `pc_plus4` out 32: `pc_out + 4`, used for link and branch base.
- `instr_valid` out 1: IF/ID holds a real instruction.

## Operation
- **Reset values:** PC = `PC_RESET`, state IDLE, `imem_req` = 0, `instruction_memory` = 32'h0 (NOP), `pc_out` = 0, `pc_plus4` = 4, `instr_valid` = 0.
- **States:** IDLE, FETCH, HOLD, DRAIN. `imem_req` = 1 in FETCH and DRAIN only.
- **IDLE:** goes to FETCH on the first edge after reset release.
- **FETCH:** `imem_addr` = PC. `imem_req` and `imem_addr` stay stable until `imem_ready`.
  - Ready with `stall` = 0: load IF/ID with rdata, PC and PC+4; set `instr_valid` = 1; PC += 4; stay in FETCH.
  - Ready with `stall` = 1: capture rdata and PC into the hold buffer; PC += 4; go to HOLD.
  - No ready with `stall` = 0: IF/ID clears `instr_valid` (bubble).
- **HOLD:** `imem_req` = 0. When `stall` = 0, move the buffer into IF/ID with `instr_valid` = 1 and go to FETCH.
- **stall = 1, any state:** IF/ID registers are unchanged, including `instr_valid`.
- **redirect (highest priority, any state, overrides stall):**
  - PC <= {redirect_pc[31:2], 2'b00}.
  - IF/ID flushed: `instruction_memory` = 0, `instr_valid` = 0.
  - Hold buffer discarded.
  - If in FETCH with `imem_ready` = 0: go to DRAIN. Otherwise go to FETCH.
- **DRAIN:** keeps the old request stable until `imem_ready`, discards the data, then goes to FETCH at the new PC. A further redirect in DRAIN only updates the PC.
- **PC arithmetic:** modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- **Zero-wait memory** (ready in the same cycle as req): one instruction per cycle. A word fetched in cycle N is visible on IF/ID outputs after edge N.
- **Redirect to first valid target instruction:** redirect sampled at edge N, target address issued in cycle N+1, `instr_valid` high after edge N+1 (zero-wait memory).
- **Stall release from HOLD:** buffered word appears after the first edge with `stall` = 0. The next request issues in the following cycle.
- **Reset mid-request:** immediate return to reset values. Memory must tolerate `imem_req` dropping without ready.

## Structure
- **Shared package `mips_pkg`:** `NOP_WORD` (32'h0), `PC_INC` (4), `fetch_state_t` enum {IDLE, FETCH, HOLD, DRAIN}.
- **Sub-module `if_id_reg`:** 32+32+32+1-bit register with load, hold and flush controls, reused by later pipeline registers.
- **Top level:** PC register, FSM, and a one-entry hold buffer.

## Test plan
- **Reset, zero-wait memory:** words 32'h04224032 then 32'h04644820 returned -> `instr_valid` 0 during reset, then `pc_out` 0 then 4 on consecutive cycles, `pc_plus4` 4 then 8.
- **Two-cycle memory latency:** `imem_addr` stable for 2 cycles per word; bubble cycle has `instr_valid` = 0; throughput one word per 2 cycles.
- **Stall coinciding with ready at PC 8:** word held in HOLD; `imem_req` = 0; after 3 stall cycles the word appears with `pc_out` = 8, and the next request is to 12.
- **Redirect to 32'h0000_0043 during a pending two-cycle fetch:** old data discarded in DRAIN; next request at 32'h40; IF/ID flushed to 0 with `instr_valid` = 0.
- **Redirect and stall asserted together in HOLD:** buffer dropped, redirect wins, fetch resumes at the target.
- **PC_RESET = 32'hFFFF_FFFC:** second fetch address is 32'h0000_0000.
